// File: rtl/fft_pkg.sv
// Shared FFT pipeline package: default widths and the index bit-reversal helper.
package fft_pkg;

    localparam int WIDTH_DEF  = 24;
    localparam int N_LOG2_DEF = 6;
    localparam int BITREV_MAX = 16;

    // Reverses the low nbits of idx; bits at and above nbits come back zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] idx,
                                                     input int nbits);
        logic [BITREV_MAX-1:0] rev;
        logic [BITREV_MAX-1:0] src;
        rev = {BITREV_MAX{1'b0}};
        src = idx;
        for (int b = 0; b < BITREV_MAX; b++) begin
            if (b < nbits) begin
                rev = {rev[BITREV_MAX-2:0], src[0]};
                src = {1'b0, src[BITREV_MAX-1:1]};
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: register array with a single write port and an
// asynchronous read port.
module fft_reorder_bank #(
    parameter int DW = 48,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Sample storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer: takes bit-reversed FFT samples and re-emits each
// frame in natural order through a ping-pong pair of banks.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_R,
    input  logic [WIDTH-1:0] in_I,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_R,
    output logic [WIDTH-1:0] out_I,
    output logic             out_last
);

    localparam int DW = 2 * WIDTH;
    localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
    localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1'b1);

    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [N_LOG2-1:0] r_wr_cnt;
    logic [N_LOG2-1:0] r_rd_cnt;

    logic              w_wr_fire;
    logic              w_wr_done;
    logic              w_load;
    logic              w_rd_done;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [N_LOG2-1:0] w_wr_addr;
    logic [DW-1:0]     w_wdata;
    logic [DW-1:0]     w_rdata [2];
    logic [DW-1:0]     w_rd_sel;

    assign in_ready  = ~r_full[r_wr_bank];
    assign w_wr_fire = in_valid & in_ready;
    assign w_wr_done = w_wr_fire & (r_wr_cnt == CNT_LAST);
    assign w_load    = r_full[r_rd_bank] & (~out_valid | out_ready);
    assign w_rd_done = w_load & (r_rd_cnt == CNT_LAST);
    assign w_wr_addr = N_LOG2'(bitrev(BITREV_MAX'(r_wr_cnt), N_LOG2));
    assign w_wdata   = {in_R, in_I};
    assign w_rd_sel  = w_rdata[r_rd_bank];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_reorder_bank #(
            .DW (DW),
            .AW (N_LOG2)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr_fire && (r_wr_bank == 1'(g))),
            .i_waddr (w_wr_addr),
            .i_wdata (w_wdata),
            .i_raddr (r_rd_cnt),
            .o_rdata (w_rdata[g])
        );
    end

    // Set and clear always hit different banks, so both can apply on one edge.
    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_wr_done) begin
            w_full_set[r_wr_bank] = 1'b1;
        end else begin
            w_full_set = 2'b00;
        end
        if (w_rd_done) begin
            w_full_clr[r_rd_bank] = 1'b1;
        end else begin
            w_full_clr = 2'b00;
        end
    end

    // Bank-full flags, bank selects and the power-of-two wrapping counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= {N_LOG2{1'b0}};
            r_rd_cnt  <= {N_LOG2{1'b0}};
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_load) begin
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Output register: load when free or being consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_R     <= {WIDTH{1'b0}};
            out_I     <= {WIDTH{1'b0}};
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_last  <= (r_rd_cnt == CNT_LAST);
            out_R     <= w_rd_sel[DW-1:WIDTH];
            out_I     <= w_rd_sel[WIDTH-1:0];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output-side reorder buffer for the SDF radix-2 FFT pipeline.
- Accepts one complex sample per cycle in bit-reversed order, as the last butterfly/delay-line stage emits it, and re-emits each frame in natural index order.
- Ping-pong buffer with two N-entry banks, so one frame is written while the previous one is read.
- Sits between the final FFT stage and the downstream consumer; valid/ready on both sides.

Parameters:
- WIDTH, 24, bit width of each real/imag component.
- N_LOG2, 6, log2 of frame length; N = 2**N_LOG2 samples per frame.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample this cycle
- in_R  in  WIDTH  input real part
- in_I  in  WIDTH  input imaginary part
- out_valid  out  1  out_R/out_I hold a valid sample
- out_ready  in  1  downstream accepts the sample this cycle
- out_R  out  WIDTH  output real part, registered
- out_I  out  WIDTH  output imaginary part, registered
- out_last  out  1  high with the final sample (index N-1) of a frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - out_valid=0, out_last=0, out_R=0, out_I=0.
  - Bank memory is not reset; contents are don't-care.
- Write side:
  - in_ready = !full[wr_bank], combinational.
  - Accept on in_valid && in_ready: store {in_R,in_I} at address bitrev(wr_cnt) of wr_bank (bitrev over N_LOG2 bits), then wr_cnt++.
  - On accepting the sample with wr_cnt==N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - in_valid while in_ready=0 is ignored; upstream must hold the sample.
- Read side, output register load:
  - load = full[rd_bank] && (!out_valid || out_ready).
  - On load: out_R/out_I <= bank[rd_bank][rd_cnt], out_valid<=1, out_last<=(rd_cnt==N-1), rd_cnt++.
  - Loading rd_cnt==N-1 clears full[rd_bank], toggles rd_bank, and wraps rd_cnt.
  - If out_valid && out_ready && !full[rd_bank]: out_valid<=0, out_last<=0; data bits keep their last value.
  - If out_valid && !out_ready: out_R, out_I, out_last held stable.
- Latency:
  - The bank becomes full on edge E, the one accepting sample N-1.
  - First output (index 0) is valid after edge E+1.
- Throughput:
  - With out_ready held 1 and in_valid held 1, the block streams with no bubbles and in_ready never drops.
  - This holds because the reader frees a bank on the same edge the writer completes the other bank.
- Simultaneous events:
  - Set of full[wr_bank] and clear of full[rd_bank] on the same edge always target different banks; both take effect.
  - Same-edge write and read of one bank cannot occur, because a full bank is never written.
- Both banks full: in_ready=0 until the reader releases a bank.
- Reset mid-frame: the partial frame and any buffered frames are discarded; the first frame after reset starts at wr_cnt=0.

Decomposition:
- Shared package fft_pkg: WIDTH and N_LOG2 defaults; bitrev function (N_LOG2-bit reverse). The same package is used by the FFT stage modules.
- Sub-module fft_reorder_bank: N x 2*WIDTH register array, one write port, one combinational read port; instantiated twice.
- Top level holds the counters, full flags, handshake logic and output register.

Test Plan (N_LOG2=3, WIDTH=24):
- Single frame:
  - Stimulus: in_R=k, in_I=100+k for k=0..7 in consecutive cycles; out_ready=1.
  - Response: out_R sequence 0,4,2,6,1,5,3,7 with matching in_I pairs; out_last only on the 8th output; first out_valid 1 cycle after the bank-full edge.
- Continuous streaming:
  - Stimulus: 4 back-to-back frames; out_ready=1.
  - Response: in_ready constantly 1; 32 outputs with no gaps; each frame's out_R order matches the single-frame pattern.
- Backpressure:
  - Stimulus: out_ready=0 throughout 3 frames of input.
  - Response: in_ready drops to 0 after the 16th accepted sample; out_R/out_I frozen at frame 0 index 0.
  - Then release out_ready: all 16 buffered outputs drain in order, and in_ready returns high on the edge after frame 0's last load.
- Random stalls:
  - Stimulus: in_valid and out_ready random at 50%.
  - Response: scoreboard of bit-reversal permutation per frame; no loss or duplication; outputs stable while stalled.
- Reset mid-frame:
  - Stimulus: rst_n pulsed low after 5 samples of frame 1, while frame 0 is mid-read.
  - Response: out_valid=0, out_R=0, out_I=0, out_last=0 asynchronously; the next full frame outputs correctly with no residue.
